prog_clk_div: RTL

- Multi-channel, runtime-programmable clock/strobe divider. Generalises the fixed single-output constant divider.
- Each channel divides i_clk by its own divisor D, loaded at runtime; reset loads DIV_INIT.
- Each channel has near-50% duty, a per-channel enable, and a tick strobe.
- Divisor updates take effect only at a period boundary, so no runt pulses occur.
- Sits between the board clock domain and GPIO/LED-rate logic. Outputs are logic-level enables/clocks on GPIO, never used as internal clocks.

---
 rtl/prog_clk_div_pkg.sv | 23 ++
 rtl/prog_clk_div_if.sv | 29 ++
 rtl/prog_clk_div_ch.sv | 79 +++++++
 rtl/prog_clk_div.sv | 58 +++++
 4 files changed

// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the programmable clock/strobe divider.
package clk_div_pkg;

    // Default geometry of the divider bank.
    localparam int DEF_N_CH     = 4;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_DIV_INIT = 7;

    // Smallest divisor that still produces a distinct high and low phase.
    localparam int MIN_DIV = 2;

    // Channel-select width; a single-channel bank still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // High-phase length ceil(d/2). Written without d+1 so the all-ones
    // divisor does not overflow.
    function automatic logic [31:0] ceil_half(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Control/status bundle of the divider bank: enables and divisor writes in,
// divided clocks, period ticks and the write-reject pulse out.
interface prog_clk_div_if
    import clk_div_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int CH_W  = ch_w(N_CH)
);
    logic [N_CH-1:0]  i_en;
    logic             i_div_we;
    logic [CH_W-1:0]  i_div_ch;
    logic [CNT_W-1:0] i_div_val;
    logic [N_CH-1:0]  o_clk;
    logic [N_CH-1:0]  o_tick;
    logic             o_err;

    // Controller side: drives enables and writes, watches the outputs.
    modport master (
        output i_en, i_div_we, i_div_ch, i_div_val,
        input  o_clk, o_tick, o_err
    );

    // Divider side.
    modport slave (
        input  i_en, i_div_we, i_div_ch, i_div_val,
        output o_clk, o_tick, o_err
    );
endinterface

// File: rtl/prog_clk_div_ch.sv
// One divider channel: period counter, active and pending divisor, and the
// registered divided clock / period tick. A new divisor is only adopted at a
// period boundary or while the channel is stopped, so no runt pulses occur.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DIV_INIT = DEF_DIV_INIT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_clk,
    output logic             o_tick
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend_div;
    logic             pend;
    logic             run;

    logic             wrap;
    logic [CNT_W-1:0] div_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] high_n;

    // Last cycle of the current period; compared with >= so a counter can
    // never run past the divisor.
    assign wrap   = run && (cnt >= div - CNT_W'(1));
    // The pending divisor is adopted exactly when the period wraps.
    assign div_n  = (wrap && pend) ? pend_div : div;
    // A stopped channel restarts at the top of a fresh period.
    assign cnt_n  = (!run || wrap) ? '0 : cnt + CNT_W'(1);
    assign high_n = CNT_W'(ceil_half(32'(div_n)));

    // Counter, divisor bookkeeping and registered outputs.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every read
        // in this block sees the pre-edge value, independent of statement order.
        if (i_rst) begin
            cnt      <= '0;
            div      <= CNT_W'(DIV_INIT);
            pend_div <= '0;
            pend     <= 1'b0;
            run      <= 1'b0;
            o_clk    <= 1'b0;
            o_tick   <= 1'b0;
        end else begin
            if (!i_en) begin
                run    <= 1'b0;
                cnt    <= '0;
                o_clk  <= 1'b0;
                o_tick <= 1'b0;
                if (pend) begin
                    div  <= pend_div;
                    pend <= 1'b0;
                end
            end else begin
                run    <= 1'b1;
                cnt    <= cnt_n;
                div    <= div_n;
                o_clk  <= (cnt_n < high_n);
                o_tick <= (cnt_n == '0);
                if (wrap) begin
                    pend <= 1'b0;
                end
            end
            // NOTE: placed after the consume logic so a write landing on the
            // wrap edge re-arms the pending flag; the wrap itself used the
            // value registered before this edge.
            if (i_wr) begin
                pend_div <= i_val;
                pend     <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel runtime-programmable clock/strobe divider. Decodes divisor
// writes, rejects illegal ones with a one-cycle error pulse, and runs one
// independent divider per channel.
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DIV_INIT = DEF_DIV_INIT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    prog_clk_div_if.slave bus
);
    localparam int CH_W = ch_w(N_CH);

    logic            val_ok;
    logic            ch_ok;
    logic [N_CH-1:0] clk_vec;
    logic [N_CH-1:0] tick_vec;

    // A divisor below MIN_DIV has no low phase; a channel index past the
    // bank (possible when N_CH is not a power of two) addresses nothing.
    assign val_ok = (bus.i_div_val >= CNT_W'(MIN_DIV));
    assign ch_ok  = (32'(bus.i_div_ch) < 32'(N_CH));

    // Rejected-write pulse, registered one cycle after the write strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_err <= 1'b0;
        end else begin
            bus.o_err <= bus.i_div_we && !(val_ok && ch_ok);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic wr;

        assign wr = bus.i_div_we && val_ok && ch_ok &&
                    (bus.i_div_ch == CH_W'(k));

        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (bus.i_en[k]),
            .i_wr   (wr),
            .i_val  (bus.i_div_val),
            .o_clk  (clk_vec[k]),
            .o_tick (tick_vec[k])
        );
    end

    assign bus.o_clk  = clk_vec;
    assign bus.o_tick = tick_vec;
endmodule
